// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES round controller.
// Contents:
//   state_e          controller states IDLE/LOAD/ROUND/FINAL/HOLD
//   NR_128, NR_256   round counts for AES-128 and AES-256
//   KM_AES128/256    KEY_MODE encoding
//   nr_for_mode()    maps a KEY_MODE value to its round count
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_256 = 14;

  localparam logic KM_AES128 = 1'b0;
  localparam logic KM_AES256 = 1'b1;

  function automatic logic [3:0] nr_for_mode(input logic key_mode,
                                              input int unsigned nr128,
                                              input int unsigned nr256);
    nr_for_mode = (key_mode == KM_AES256) ? 4'(nr256) : 4'(nr128);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and strobe bundle between a block requester and the AES round
// controller.
// Signals:
//   start, key_mode, abort, out_ready   requester -> controller
//   key_load, key_en, data_load         controller -> key generator / datapath
//   round_idx[3:0], final_rnd           current round and last-round flag
//   busy, out_valid                     controller status / result handshake
// Modports: master = requester side, slave = controller side.
interface aes_round_ctrl_if;
  logic       start;
  logic       key_mode;
  logic       abort;
  logic       out_ready;
  logic       key_load;
  logic       key_en;
  logic       data_load;
  logic [3:0] round_idx;
  logic       final_rnd;
  logic       busy;
  logic       out_valid;

  modport master (
    output start, key_mode, abort, out_ready,
    input  key_load, key_en, data_load, round_idx, final_rnd, busy, out_valid
  );

  modport slave (
    input  start, key_mode, abort, out_ready,
    output key_load, key_en, data_load, round_idx, final_rnd, busy, out_valid
  );
endinterface

// File: rtl/aes_round_cnt.sv
// 4-bit round counter for the AES round controller.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clr_i        force the count to 0 (highest priority)
//   load1_i      load the count with 1
//   inc_i        increment the count
//   nr_i[3:0]    round count of the current block
//   cnt_o[3:0]   registered count
//   term_o       count equals nr_i-1, i.e. the next round is the last one
module aes_round_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       load1_i,
  input  logic       inc_i,
  input  logic [3:0] nr_i,
  output logic [3:0] cnt_o,
  output logic       term_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = 4'd0;
    else if (load1_i) cnt_d = 4'd1;
    else if (inc_i)   cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == (nr_i - 4'd1));

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: drives key-generator and round-datapath strobes for
// one block of AES-128 (NR_128 rounds) or AES-256 (NR_256 rounds). Holds
// no key or data itself.
// Ports:
//   clk     single clock
//   rst     synchronous active-high reset
//   bus     aes_round_ctrl_if.slave: start/key_mode/abort/out_ready in,
//           key_load/key_en/data_load/round_idx/final_rnd/busy/out_valid out
// Every output is decoded from the registered state and round counter, so
// nothing on the input side reaches an output in the same cycle.
module aes_round_ctrl #(
  parameter int unsigned NR_128 = aes_ctrl_pkg::NR_128,
  parameter int unsigned NR_256 = aes_ctrl_pkg::NR_256
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.slave  bus
);
  import aes_ctrl_pkg::*;

  state_e     state_q, state_d;
  logic [3:0] nr_q, nr_d;
  logic       cnt_clr, cnt_load1, cnt_inc;
  logic [3:0] cnt;
  logic       cnt_term;

  aes_round_cnt u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .load1_i (cnt_load1),
    .inc_i   (cnt_inc),
    .nr_i    (nr_q),
    .cnt_o   (cnt),
    .term_o  (cnt_term)
  );

  // Next-state logic; abort takes priority over every other request.
  always_comb begin
    state_d   = state_q;
    nr_d      = nr_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Counter is held at 0 so round_idx reads 0 while idle.
        cnt_clr = 1'b1;
        if (bus.start && !bus.abort) begin
          state_d = ST_LOAD;
          nr_d    = nr_for_mode(bus.key_mode, NR_128, NR_256);
        end
      end
      ST_LOAD: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else begin
          state_d   = ST_ROUND;
          cnt_load1 = 1'b1;
        end
      end
      ST_ROUND: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else begin
          // The increment out of round Nr-1 lands the counter on Nr for FINAL.
          cnt_inc = 1'b1;
          if (cnt_term) state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // start is deliberately not looked at here.
        if (bus.abort || bus.out_ready) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      nr_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      nr_q    <= nr_d;
    end
  end

  // Output decode from registered state and counter only.
  always_comb begin
    bus.key_load  = (state_q == ST_LOAD);
    bus.data_load = (state_q == ST_LOAD);
    bus.key_en    = (state_q == ST_ROUND) || (state_q == ST_FINAL);
    bus.final_rnd = (state_q == ST_FINAL);
    bus.busy      = (state_q == ST_LOAD) || (state_q == ST_ROUND) ||
                    (state_q == ST_FINAL);
    bus.out_valid = (state_q == ST_HOLD);
    bus.round_idx = (state_q == ST_IDLE) ? 4'd0 : cnt;
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(.NR_128(10), .NR_256(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Timeline model: a block is "active" with step t counted from the
  // accept edge; t=0 load, 1..nr-1 rounds, nr final, nr+1 waiting for ready.
  bit m_act = 1'b0;
  int m_t   = 0;
  int m_nr  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (bus.start && !bus.abort) begin
        m_act = 1'b1;
        m_t   = 0;
        m_nr  = bus.key_mode ? 14 : 10;
      end
    end else if (bus.abort) begin
      m_act = 1'b0;
    end else if (m_t > m_nr) begin
      if (bus.out_ready) m_act = 1'b0;
    end else begin
      m_t = m_t + 1;
    end
  end

  function automatic logic [10:0] model_vec();
    logic kl, ke, dl, fr, bz, ov;
    logic [3:0] idx;
    kl  = m_act && (m_t == 0);
    dl  = kl;
    ke  = m_act && (m_t >= 1) && (m_t <= m_nr);
    fr  = m_act && (m_t == m_nr);
    bz  = m_act && (m_t <= m_nr);
    ov  = m_act && (m_t == m_nr + 1);
    idx = !m_act ? 4'd0 : (m_t <= m_nr ? 4'(m_t) : 4'(m_nr));
    return {kl, ke, dl, idx, fr, bz, ov};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {bus.key_load, bus.key_en, bus.data_load, bus.round_idx,
            bus.final_rnd, bus.busy, bus.out_valid};
  endfunction

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      total = total + 1;
      if (dut_vec() !== model_vec()) begin
        bad = bad + 1;
        $display("FAIL model_cmp t=%0t actual{kl,ke,dl,idx,fr,bz,ov}=%b required=%b",
                 $time, dut_vec(), model_vec());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int req);
    total = total + 1;
    if (act != req) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_idx(input int v);
    int n = 0;
    while (bus.round_idx != 4'(v) && n < 40) begin
      tick();
      n++;
    end
    check("wait_idx_timeout", (n < 40) ? 1 : 0, 1);
  endtask

  // One block: accepts, observes strobes, optionally disturbs start/key_mode
  // while busy, stalls hold_cyc cycles in HOLD pulsing start, then releases.
  task automatic run_block(input bit mode, input int hold_cyc, input bit disturb,
                           input string tag);
    int lat = 0, n_ke = 0, n_kl = 0, fin_idx = -1, max_idx = 0;
    bus.key_mode = mode;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.key_en)    n_ke++;
      if (bus.key_load)  n_kl++;
      if (bus.final_rnd) fin_idx = int'(bus.round_idx);
      if (int'(bus.round_idx) > max_idx) max_idx = int'(bus.round_idx);
      if (disturb) begin
        bus.start    = lat[0];
        bus.key_mode = ~bus.key_mode;
      end
      tick();
      lat++;
    end
    bus.start    = 1'b0;
    bus.key_mode = mode;
    check({tag, "_latency"}, lat, mode ? 15 : 11);
    check({tag, "_key_en_cnt"}, n_ke, mode ? 14 : 10);
    check({tag, "_key_load_cnt"}, n_kl, 1);
    check({tag, "_final_idx"}, fin_idx, mode ? 14 : 10);
    check({tag, "_max_idx"}, max_idx, mode ? 14 : 10);
    for (int i = 0; i < hold_cyc; i++) begin
      bus.start = i[0];
      tick();
      check({tag, "_hold_valid"}, int'(bus.out_valid), 1);
      check({tag, "_hold_key_en"}, int'(bus.key_en), 0);
      check({tag, "_hold_idx"}, int'(bus.round_idx), mode ? 14 : 10);
    end
    // Release with start high: start must not be taken in HOLD.
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check({tag, "_release_idle_busy"}, int'(bus.busy), 0);
    check({tag, "_release_no_load"}, int'(bus.key_load), 0);
    check({tag, "_release_valid"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.key_mode  = 1'b0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_vec", int'(dut_vec()), 0);
    tick();
    check("idle_vec", int'(dut_vec()), 0);

    // AES-128 and AES-256 plain runs.
    run_block(1'b0, 0, 1'b0, "aes128");
    tick();
    run_block(1'b1, 0, 1'b0, "aes256");

    // Back-to-back with backpressure.
    run_block(1'b0, 5, 1'b0, "bp");

    // Abort at round 4, then a full block.
    bus.key_mode = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idx(4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_valid", int'(bus.out_valid), 0);
    check("abort_idx", int'(bus.round_idx), 0);
    check("abort_key_en", int'(bus.key_en), 0);
    run_block(1'b0, 0, 1'b0, "post_abort");

    // Reset at round 6.
    bus.key_mode = 1'b1;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idx(6);
    rst = 1'b1;
    tick();
    check("rst_mid_vec", int'(dut_vec()), 0);
    rst = 1'b0;
    tick();
    check("rst_after_vec", int'(dut_vec()), 0);

    // Start while busy and key_mode toggling must not alter the block.
    run_block(1'b0, 1, 1'b1, "disturb128");
    run_block(1'b1, 0, 1'b1, "disturb256");

    // Abort and start together in IDLE.
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    check("abort_start_key_load", int'(bus.key_load), 0);
    check("abort_start_busy", int'(bus.busy), 0);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    tick();
    check("abort_start_idle_vec", int'(dut_vec()), 0);

    // Abort in HOLD.
    bus.key_mode = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idx(10);
    tick();
    check("hold_reached", int'(bus.out_valid), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("hold_abort_valid", int'(bus.out_valid), 0);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR_128, default 10, round count for AES-128.
REQ-002 Parameter NR_256, default 14, round count for AES-256.
REQ-003 CLK  in  1  single clock; all state changes on the rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 START  in  1  request to process one block; accepted only in IDLE.
REQ-006 KEY_MODE  in  1  0 = AES-128, 1 = AES-256; sampled on START accept.
REQ-007 ABORT  in  1  cancel the current operation.
REQ-008 OUT_READY  in  1  consumer accepts the result.
REQ-009 KEY_LOAD  out  1  loads the main key into the key generator; k0 becomes current.
REQ-010 KEY_EN  out  1  advances the key generator by one subkey.
REQ-011 DATA_LOAD  out  1  loads plaintext and applies the initial AddRoundKey with k0.
REQ-012 ROUND_IDX  out  4  current round number, 0..14.
REQ-013 FINAL_RND  out  1  current round is the last round; the datapath skips MixColumns.
REQ-014 BUSY  out  1  high in LOAD, ROUND and FINAL.
REQ-015 OUT_VALID  out  1  result valid; held until the handshake completes.

Function
REQ-016 FSM states: IDLE, LOAD, ROUND, FINAL, HOLD.
REQ-017 All outputs decode from registered state and counter only; no combinational input-to-output path.
REQ-018 IDLE with START=1 moves to LOAD at the next edge; KEY_MODE is latched into an internal Nr of 10 or 14.
REQ-019 LOAD lasts 1 cycle: KEY_LOAD=1, DATA_LOAD=1, ROUND_IDX=0; next state is ROUND with ROUND_IDX=1.
REQ-020 ROUND: KEY_EN=1; ROUND_IDX increments by 1 each cycle while it is below Nr-1; ROUND_IDX=Nr-1 moves to FINAL.
REQ-021 FINAL lasts 1 cycle: KEY_EN=1, FINAL_RND=1, ROUND_IDX=Nr; next state is HOLD.
REQ-022 Exactly Nr KEY_EN cycles and exactly 1 KEY_LOAD cycle occur per accepted block.
REQ-023 HOLD: OUT_VALID=1, KEY_EN=0, ROUND_IDX frozen at Nr; OUT_READY=1 moves to IDLE at the next edge.
REQ-024 Latency: OUT_VALID rises Nr+1 edges after the START-accept edge (11 for AES-128, 15 for AES-256).
REQ-025 START is ignored outside IDLE, including in HOLD in the same cycle as OUT_READY; back-to-back blocks take 1 IDLE cycle.
REQ-026 KEY_MODE changes after the START-accept edge have no effect until the next accept.
REQ-027 ABORT=1 in LOAD, ROUND, FINAL or HOLD moves to IDLE at the next edge, with no OUT_VALID and no further KEY_EN.
REQ-028 ABORT in IDLE has no effect; when ABORT and START are both high in IDLE, ABORT wins and START is not accepted.
REQ-029 In IDLE, all outputs are 0 and ROUND_IDX=0.

Reset
REQ-030 RST=1 at an edge forces IDLE, clears the counter and latched Nr, and drives all outputs to 0, overriding every other input, including mid-round.
REQ-031 The first START after RST deasserts restarts from LOAD; no partial state is retained.

Structure
REQ-032 Package aes_ctrl_pkg holds the state enum, the NR_128/NR_256 constants and the KEY_MODE encoding.
REQ-033 Sub-module aes_round_cnt is a 4-bit counter with clear, load-to-1, increment and terminal-compare-against-Nr inputs and outputs.
REQ-034 The block contains no key or data storage; it drives only the control strobes of the key generator and the round datapath.

Verification
REQ-035 AES-128: RST for 1 cycle, START with KEY_MODE=0 -> 1 KEY_LOAD cycle; 10 KEY_EN cycles with ROUND_IDX 1..10; FINAL_RND only at index 10; OUT_VALID at edge 11; OUT_READY=1 -> IDLE.
REQ-036 AES-256: START with KEY_MODE=1 -> 14 KEY_EN cycles, FINAL_RND at ROUND_IDX=14, OUT_VALID at edge 15.
REQ-037 Backpressure: OUT_READY held low for 5 cycles in HOLD, START pulsed -> OUT_VALID stays high, KEY_EN=0, START ignored; release -> IDLE.
REQ-038 ABORT at ROUND_IDX=4 -> IDLE next edge, BUSY=0, no OUT_VALID; next START gives a full 10-round sequence from ROUND_IDX 0.
REQ-039 RST at ROUND_IDX=6 -> all outputs 0 at the next edge; START while BUSY and a KEY_MODE toggle mid-block -> no change in sequence or length.
REQ-040 ABORT and START high together in IDLE -> remains in IDLE, KEY_LOAD stays 0.
